// File: rtl/tt_dispatch_scheduler.sv
// tt_dispatch_scheduler: walks a static schedule table against the global time base and
// issues time-triggered (TT) messages to the source FSM. Event-triggered (ET) requests fill
// the idle time between slots.
// Optional build macro TT_ET_GUARD_EN: ET is granted only when the next valid slot is more
// than GUARD ticks away. Without it, ET is granted whenever the path is idle and no TT slot
// is pending. A TT slot that collides with an ET transfer then shows up in late_cnt.

module tt_dispatch_scheduler #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned GUARD   = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [63:0]                GTB,
  input  logic                       enable,
  input  logic                       cfg_we,
  input  logic [$clog2(ENTRIES)-1:0] cfg_idx,
  input  logic                       cfg_valid,
  input  logic [PHASE_W-1:0]         cfg_offset,
  input  logic [ADDR_W-1:0]          cfg_dest,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic                       et_req,
  input  logic [ADDR_W-1:0]          et_dest,
  input  logic [LEN_W-1:0]           et_len,
  output logic                       et_grant,
  output logic                       trigger,
  output logic [ADDR_W-1:0]          destination_address,
  output logic [LEN_W-1:0]           msglen,
  input  logic                       src_done,
  output logic                       busy,
  output logic                       tt_active,
  output logic [$clog2(ENTRIES)-1:0] slot_idx,
  output logic [15:0]                late_cnt,
  output logic [15:0]                miss_cnt
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  typedef enum logic [1:0] {StIdle, StTtIssue, StEtIssue, StBusy} state_e;

  state_e              state_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [PHASE_W-1:0]  offset_q [ENTRIES];
  logic [ADDR_W-1:0]   dest_q   [ENTRIES];
  logic [LEN_W-1:0]    len_q    [ENTRIES];
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     pend_idx_q;
  logic                tt_pending_q;
  // Set once the pending slot has waited past its on-time issue edge.
  logic                pend_late_q;

  logic [PHASE_W-1:0]  phase;
  logic                cur_valid;
  logic                match;
  logic                fsm_idle;
  logic                tt_start;
  logic                et_start;
  logic                et_allowed;
  logic                unused_gtb;

  assign phase      = GTB[PHASE_W-1:0];
  assign unused_gtb = ^GTB[63:PHASE_W];
  assign cur_valid  = valid_q[ptr_q];
  assign match      = enable & cur_valid & (phase == offset_q[ptr_q]);
  assign fsm_idle   = (state_q == StIdle);
  assign tt_start   = fsm_idle & enable & tt_pending_q;
  assign et_start   = fsm_idle & enable & ~tt_pending_q & et_req & et_allowed;

`ifdef TT_ET_GUARD_EN
  localparam logic [PHASE_W-1:0] GuardTicks = PHASE_W'(GUARD);
  logic [PHASE_W-1:0] slack;
  // Modular distance to the slot under the pointer; wraps with the phase.
  assign slack      = offset_q[ptr_q] - phase;
  assign et_allowed = ~cur_valid | (slack > GuardTicks);
`else
  assign et_allowed = 1'b1;
`endif

  // Schedule table registers; a write is visible to the pointer logic on the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        offset_q[i] <= '0;
        dest_q[i]   <= '0;
        len_q[i]    <= '0;
      end
    end else if (cfg_we) begin
      valid_q[cfg_idx]  <= cfg_valid;
      offset_q[cfg_idx] <= cfg_offset;
      dest_q[cfg_idx]   <= cfg_dest;
      len_q[cfg_idx]    <= cfg_len;
    end
  end

  // Table walk: skip invalid entries, hold on a valid one until its phase arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      pend_idx_q   <= '0;
      tt_pending_q <= 1'b0;
      pend_late_q  <= 1'b0;
      late_cnt     <= '0;
      miss_cnt     <= '0;
    end else if (!enable) begin
      ptr_q        <= '0;
      tt_pending_q <= 1'b0;
      pend_late_q  <= 1'b0;
    end else begin
      if (!cur_valid || match) begin
        ptr_q <= ptr_q + IdxW'(1);
      end
      // A new match always replaces the pending slot, even one being issued this edge.
      if (match) begin
        tt_pending_q <= 1'b1;
        pend_idx_q   <= ptr_q;
        pend_late_q  <= 1'b0;
        if (tt_pending_q && miss_cnt != 16'hFFFF) begin
          miss_cnt <= miss_cnt + 16'd1;
        end
      end else if (tt_start) begin
        tt_pending_q <= 1'b0;
      end else if (tt_pending_q) begin
        pend_late_q <= 1'b1;
      end
      if (tt_start && pend_late_q && late_cnt != 16'hFFFF) begin
        late_cnt <= late_cnt + 16'd1;
      end
    end
  end

  // Issue FSM with registered trigger/grant/busy outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= StIdle;
      trigger             <= 1'b0;
      et_grant            <= 1'b0;
      busy                <= 1'b0;
      tt_active           <= 1'b0;
      destination_address <= '0;
      msglen              <= '0;
      slot_idx            <= '0;
    end else begin
      trigger  <= 1'b0;
      et_grant <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tt_start) begin
            state_q             <= StTtIssue;
            trigger             <= 1'b1;
            destination_address <= dest_q[pend_idx_q];
            msglen              <= len_q[pend_idx_q];
            slot_idx            <= pend_idx_q;
          end else if (et_start) begin
            state_q             <= StEtIssue;
            trigger             <= 1'b1;
            et_grant            <= 1'b1;
            destination_address <= et_dest;
            msglen              <= et_len;
          end
        end
        StTtIssue: begin
          state_q   <= StBusy;
          busy      <= 1'b1;
          tt_active <= 1'b1;
        end
        StEtIssue: begin
          state_q   <= StBusy;
          busy      <= 1'b1;
          tt_active <= 1'b0;
        end
        StBusy: begin
          if (src_done) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            tt_active <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_dispatch_scheduler.sv
// Bench for tt_dispatch_scheduler: directed scenarios plus a randomized run, all checked
// every cycle against a timeline model (issue/done edge numbers, slot match edges).

module tb_tt_dispatch_scheduler;

  localparam int E = 8;
  localparam int unsigned G = 64;
`ifdef TT_ET_GUARD_EN
  localparam bit GuardOn = 1'b1;
`else
  localparam bit GuardOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] gtb;
  logic        enable, cfg_we, cfg_valid, et_req, src_done;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_offset;
  logic [31:0] cfg_dest, et_dest;
  logic [9:0]  cfg_len, et_len;
  logic        et_grant, trigger, busy, tt_active;
  logic [31:0] destination_address;
  logic [9:0]  msglen;
  logic [2:0]  slot_idx;
  logic [15:0] late_cnt, miss_cnt;

  always #5 clk = ~clk;

  tt_dispatch_scheduler #(
    .ENTRIES(E), .PHASE_W(16), .ADDR_W(32), .LEN_W(10), .GUARD(G)
  ) dut (
    .clk(clk), .reset_n(reset_n), .GTB(gtb), .enable(enable),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_offset(cfg_offset),
    .cfg_dest(cfg_dest), .cfg_len(cfg_len),
    .et_req(et_req), .et_dest(et_dest), .et_len(et_len), .et_grant(et_grant),
    .trigger(trigger), .destination_address(destination_address), .msglen(msglen),
    .src_done(src_done), .busy(busy), .tt_active(tt_active), .slot_idx(slot_idx),
    .late_cnt(late_cnt), .miss_cnt(miss_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: table contents, scan position, the pending slot with the edge it matched on,
  // and the current transfer as a pair of edge numbers (issue, done).
  bit          m_valid [E];
  int unsigned m_off   [E];
  logic [31:0] m_dest  [E];
  logic [9:0]  m_len   [E];
  int          m_ptr, m_pidx;
  bit          m_pend;
  longint      m_pmatch, cyc, issue_edge, done_edge;
  bit          xfer_tt;
  logic [31:0] o_dest;
  logic [9:0]  o_len;
  logic [2:0]  o_slot;
  logic [15:0] o_late, o_miss;
  bit          exp_trig, exp_grant, exp_busy, exp_tta;

  // Stimulus helpers.
  bit          auto_done, rnd_done;
  int          done_delay, done_cnt;
  logic [15:0] last_phase;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < E; i++) m_valid[i] = 1'b0;
    m_ptr = 0; m_pidx = 0; m_pend = 1'b0; m_pmatch = 0;
    issue_edge = -1; done_edge = -1; xfer_tt = 1'b0;
    o_dest = '0; o_len = '0; o_slot = '0; o_late = '0; o_miss = '0;
    exp_trig = 1'b0; exp_grant = 1'b0; exp_busy = 1'b0; exp_tta = 1'b0;
  endtask

  task automatic model_edge();
    longint      k   = cyc;
    int          p0  = m_ptr;
    bit          pd0 = m_pend;
    int          pi0 = m_pidx;
    longint      pm0 = m_pmatch;
    int unsigned ph  = {16'd0, gtb[15:0]};
    bit          path_free, match, tti, eti, g_ok;
    path_free = (issue_edge < 0) || (done_edge >= 0 && k > done_edge);
    match     = enable && m_valid[p0] && (ph == m_off[p0]);
`ifdef TT_ET_GUARD_EN
    g_ok = !m_valid[p0] || (((m_off[p0] + 32'd65536 - ph) % 32'd65536) > G);
`else
    g_ok = 1'b1;
`endif
    tti = path_free && enable && pd0;
    eti = path_free && enable && !pd0 && et_req && g_ok;
    if (issue_edge >= 0 && done_edge < 0 && k >= issue_edge + 2 && src_done) done_edge = k;
    if (tti) begin
      issue_edge = k; done_edge = -1; xfer_tt = 1'b1;
      o_dest = m_dest[pi0]; o_len = m_len[pi0]; o_slot = 3'(pi0);
      // On time means trigger in the cycle right after the edge following the match.
      if (k > pm0 + 1 && o_late != 16'hFFFF) o_late++;
    end else if (eti) begin
      issue_edge = k; done_edge = -1; xfer_tt = 1'b0;
      o_dest = et_dest; o_len = et_len;
    end
    if (!enable) begin
      m_ptr = 0; m_pend = 1'b0;
    end else begin
      if (match) begin
        if (pd0 && o_miss != 16'hFFFF) o_miss++;
        m_pend = 1'b1; m_pidx = p0; m_pmatch = k;
      end else if (tti) begin
        m_pend = 1'b0;
      end
      if (!m_valid[p0] || match) m_ptr = (p0 + 1) % E;
    end
    if (cfg_we) begin
      m_valid[cfg_idx] = cfg_valid;
      m_off[cfg_idx]   = {16'd0, cfg_offset};
      m_dest[cfg_idx]  = cfg_dest;
      m_len[cfg_idx]   = cfg_len;
    end
    exp_trig  = (issue_edge == k);
    exp_grant = exp_trig && !xfer_tt;
    exp_busy  = (issue_edge >= 0) && (k >= issue_edge + 1) && (done_edge < 0 || k < done_edge);
    exp_tta   = exp_busy && xfer_tt;
  endtask

  task automatic check_outputs();
    check($sformatf("ctl@%0d", cyc), {trigger, et_grant, busy, tt_active},
          {exp_trig, exp_grant, exp_busy, exp_tta});
    check($sformatf("data@%0d", cyc), {destination_address, msglen, slot_idx},
          {o_dest, o_len, o_slot});
    check($sformatf("cnt@%0d", cyc), {late_cnt, miss_cnt}, {o_late, o_miss});
  endtask

  // One clock: DUT and model advance on the edge, outputs compared on the falling edge,
  // then the next inputs are driven.
  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    cyc++;
    @(negedge clk);
    check_outputs();
    last_phase = gtb[15:0];
    gtb        = gtb + 64'd1;
    cfg_we     = 1'b0;
    src_done   = 1'b0;
    if (exp_grant) et_req = 1'b0;
    if (exp_trig) begin
      done_cnt = rnd_done ? int'($urandom_range(1, 30)) : done_delay;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0 && auto_done) src_done = 1'b1;
    end
  endtask

  task automatic write_entry(input int idx, input bit v, input logic [15:0] off,
                             input logic [31:0] d, input logic [9:0] l);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_valid = v;
    cfg_offset = off; cfg_dest = d; cfg_len = l;
    step();
  endtask

  task automatic wait_trig(input int limit, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (trigger) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  logic [15:0] late_before, miss_before;
  int          n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; gtb = '0; enable = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0;
    cfg_offset = '0; cfg_dest = '0; cfg_len = '0; et_req = 1'b0; et_dest = '0; et_len = '0;
    src_done = 1'b0; auto_done = 1'b1; rnd_done = 1'b0; done_delay = 20; done_cnt = 0;
    cyc = 0; last_phase = '0;
    model_reset();
    step();
    check("reset_outs", {trigger, et_grant, busy, tt_active, destination_address, msglen,
                         slot_idx, late_cnt, miss_cnt}, '0);
    step();
    reset_n = 1'b1;
    step();

    // Single slot at 0x0100.
    write_entry(0, 1'b1, 16'h0100, 32'h0000_0203, 10'd16);
    gtb = 64'h00F0; enable = 1'b1;
    wait_trig(100, "s1");
    check("s1_phase", last_phase, 16'h0101);
    check("s1_dest", destination_address, 32'h0000_0203);
    check("s1_len", msglen, 10'd16);
    check("s1_slot", slot_idx, 3'd0);
    step();
    check("s1_busy", {busy, tt_active}, 2'b11);
    repeat (24) step();
    check("s1_idle", busy, 1'b0);

    // TT pending and ET request together in idle: TT first, ET on first idle after done.
    enable = 1'b0; step();
    write_entry(0, 1'b1, 16'h0040, 32'h0000_0A01, 10'd5);
    done_delay = 5; gtb = 64'h0030; enable = 1'b1;
    for (int i = 0; i < 64 && gtb[15:0] != 16'h0041; i++) step();
    et_req = 1'b1; et_dest = 32'h0000_0B02; et_len = 10'd7;
    wait_trig(10, "prio");
    check("prio_tt_first", {et_grant, slot_idx}, {1'b0, 3'd0});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(); n++;
      if (et_grant) break;
    end
    check("prio_gap", n, 7);
    repeat (10) step();

    // Slot 40 ticks ahead with an ET request waiting.
    enable = 1'b0; step();
    write_entry(0, 1'b1, 16'h0200, 32'h0000_0C03, 10'd9);
    done_delay = 60; gtb = 64'h01D8; enable = 1'b1;
    et_req = 1'b1; et_dest = 32'h0000_0D04; et_len = 10'd11;
    wait_trig(100, "guard");
    check("guard_first_et", et_grant, GuardOn ? 1'b0 : 1'b1);
    repeat (160) step();
    check("guard_late", late_cnt, GuardOn ? 16'd0 : 16'd1);
    check("guard_et_done", et_req, 1'b0);

    // Back-to-back slots with src_done withheld.
    late_before = o_late; miss_before = o_miss;
    enable = 1'b0; step();
    write_entry(0, 1'b1, 16'h0010, 32'h0000_0E05, 10'd3);
    write_entry(1, 1'b1, 16'h0011, 32'h0000_0F06, 10'd4);
    gtb = 64'h0008; enable = 1'b1; auto_done = 1'b0; done_delay = 5;
    repeat (30) step();
    check("ovr_miss", miss_cnt, miss_before + 16'd1);
    check("ovr_busy", busy, 1'b1);
    auto_done = 1'b1; src_done = 1'b1;
    wait_trig(10, "ovr");
    check("ovr_slot", slot_idx, 3'd1);
    check("ovr_dest", destination_address, 32'h0000_0F06);
    check("ovr_late", late_cnt, late_before + 16'd1);
    repeat (10) step();

    // Entries 7 and 0 only, firing across the phase wrap.
    enable = 1'b0; step();
    write_entry(1, 1'b0, 16'h0, 32'h0, 10'd0);
    write_entry(0, 1'b0, 16'h0, 32'h0, 10'd0);
    write_entry(7, 1'b1, 16'hFFF0, 32'h0000_1007, 10'd12);
    gtb = 64'h0000_0001_0000_FFC0; enable = 1'b1;
    repeat (10) step();
    write_entry(0, 1'b1, 16'h0005, 32'h0000_1000, 10'd13);
    wait_trig(100, "wrap7");
    check("wrap7_slot", {slot_idx, last_phase}, {3'd7, 16'hFFF1});
    wait_trig(100, "wrap0");
    check("wrap0_slot", {slot_idx, last_phase}, {3'd0, 16'h0006});

    // Reset during a transfer.
    repeat (3) step();
    check("rst_pre_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_async", {trigger, et_grant, busy, tt_active, destination_address, msglen,
                        slot_idx, late_cnt, miss_cnt}, '0);
    model_reset(); done_cnt = 0;
    step(); step();
    reset_n = 1'b1; gtb = 64'hFFE8; enable = 1'b1;
    n = 0;
    repeat (40) begin
      step();
      if (trigger) n++;
    end
    check("rst_no_trig", n, 0);

    // Randomized table, ET traffic, enable drops and stray writes.
    enable = 1'b0; step();
    begin
      int unsigned acc = $urandom_range(0, 65535);
      gtb = {32'($urandom), 16'd0, 16'(acc)} - 64'd10;
      for (int i = 0; i < E; i++) begin
        acc = acc + $urandom_range(15, 60);
        write_entry(i, $urandom_range(0, 3) != 0, 16'(acc), $urandom, 10'($urandom_range(0, 1023)));
      end
      gtb = gtb - 64'(E);
    end
    rnd_done = 1'b1;
    repeat (800) begin
      if (!et_req && $urandom_range(0, 7) == 0) begin
        et_req = 1'b1; et_dest = $urandom; et_len = 10'($urandom_range(0, 1023));
      end
      enable = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 99) == 0) begin
        cfg_we = 1'b1; cfg_idx = 3'($urandom_range(0, 7)); cfg_valid = 1'($urandom_range(0, 1));
        cfg_offset = gtb[15:0] + 16'($urandom_range(5, 80));
        cfg_dest = $urandom; cfg_len = 10'($urandom_range(0, 1023));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
